// File: rtl/ooo_types_pkg.sv
// Shared types for the fetch-side memory responder and related core blocks.
//   fetch_state_t : responder FSM states (IDLE, WAIT)
//   word_addr_t   : request queue entry, a word address (byte address >> 2)
package ooo_types_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   localparam int unsigned WORD_ADDR_W = 30;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with single-cycle clear.
//   clk, rst_n        : clock, async active-low reset
//   i_push / i_wdata  : write strobe and data (ignored when full)
//   i_pop             : advance head (ignored when empty)
//   i_clear           : drop all entries, takes priority over push/pop
//   o_rdata           : current head entry
//   o_full / o_empty  : status from the registered count
//   o_count           : number of stored entries
module fifo_sync #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 30
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   input  logic                   i_clear,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A pop in the same cycle does not make room for a push.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: queues fetch requests in order, issues them one
// at a time to a single-outstanding backing memory, and returns one word per
// request as a one-cycle imem_resp pulse. flush drops queued requests and
// marks any in-flight read so its data is discarded.
//   clk, rst                        : clock, async active-low reset
//   imem_addr/imem_rmask/imem_rqst  : fetch request (rmask != 0 is a read)
//   imem_ready                      : queue not full
//   imem_rdata/imem_resp            : returned word and its valid pulse
//   flush                           : discard all outstanding requests
//   mem_addr/mem_read               : backing read, held until mem_resp
//   mem_rdata/mem_resp              : backing read completion
//
// state | meaning
// IDLE  | no read outstanding; issue queue head next cycle if present
// WAIT  | read of mem_addr outstanding; complete on mem_resp
module imem_responder
   import ooo_types_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic [3:0]        imem_rmask,
   input  logic              imem_rqst,
   output logic              imem_ready,
   output logic [31:0]       imem_rdata,
   output logic              imem_resp,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_resp
);

   fetch_state_t        r_state;
   fetch_state_t        w_state_nxt;
   logic                r_discard;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_resp;
   logic [31:0]         r_rdata;
   logic                w_accept;
   logic                w_issue;
   logic                w_pop;
   logic                w_resp_ok;
   logic                w_full;
   logic                w_empty;
   logic [ADDR_W-3:0]   w_head;
   logic [$clog2(DEPTH):0] w_count;
   logic                w_unused;

   assign w_unused = ^{w_count, imem_addr[1:0]};

   // A request in the flush cycle belongs to the old fetch path.
   assign w_accept = imem_rqst && (imem_rmask != 4'b0) && !w_full && !flush;

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W-2)
   ) u_req_q (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_accept),
      .i_wdata (imem_addr[ADDR_W-1:2]),
      .i_pop   (w_pop),
      .i_clear (flush),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // The in-flight address lives in r_mem_addr, so the queue can be cleared on
   // flush while mem_addr stays stable. A read marked discard has no queue
   // entry left, so its completion must not pop.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_pop       = 1'b0;
      w_resp_ok   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && !flush) begin
               w_state_nxt = WAIT;
               w_issue     = 1'b1;
            end
         end
         WAIT: begin
            if (mem_resp) begin
               w_state_nxt = IDLE;
               w_pop       = !r_discard;
               w_resp_ok   = !r_discard && !flush;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_discard  <= 1'b0;
         r_mem_addr <= '0;
         r_resp     <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_resp  <= w_resp_ok;
         if (w_resp_ok) r_rdata <= mem_rdata;
         if (w_issue) r_mem_addr <= {w_head, 2'b00};
         if (r_state == WAIT) begin
            if (mem_resp)   r_discard <= 1'b0;
            else if (flush) r_discard <= 1'b1;
         end
      end
   end

   assign imem_ready = !w_full;
   assign imem_resp  = r_resp;
   assign imem_rdata = r_rdata;
   assign mem_read   = (r_state == WAIT);
   assign mem_addr   = r_mem_addr;

endmodule
